// File: rtl/reset_seq.sv
// Sequenced reset controller: holds the network block in reset, waits for its resetdone,
// then releases the system reset. Define RESET_SEQ_SOFT_RST_EN to add the soft_rst_i input.
module reset_seq #(
  parameter int unsigned HOLD_CYCLES    = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 16777216,
  parameter int unsigned RETRY_MAX      = 7
) (
  input  logic       sys_clk_i,
  input  logic       areset_n_i,
  input  logic       resetdone_i,
`ifdef RESET_SEQ_SOFT_RST_EN
  input  logic       soft_rst_i,
`endif
  output logic       net_areset_o,
  output logic       sys_rst_n_o,
  output logic       sys_rst_o,
  output logic       resetdone_o,
  output logic       fail_o,
  output logic       link_drop_o,
  output logic [2:0] state_o
);

  localparam int unsigned HOLD_W  = $clog2(HOLD_CYCLES) + 1;
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned RETRY_W = $clog2(RETRY_MAX) + 1;

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(RETRY_MAX);

  localparam logic [2:0] ST_ASSERT   = 3'd0;
  localparam logic [2:0] ST_NET_WAIT = 3'd1;
  localparam logic [2:0] ST_RUN      = 3'd2;
  localparam logic [2:0] ST_FAIL     = 3'd3;

  logic [1:0]         rst_sync_q, rst_sync_d;
  logic [1:0]         done_sync_q, done_sync_d;
  logic [2:0]         state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
  logic               net_areset_q, net_areset_d;
  logic               sys_rst_n_q, sys_rst_n_d;
  logic               sys_rst_q, sys_rst_d;
  logic               resetdone_q, resetdone_d;
  logic               fail_q, fail_d;
  logic               link_drop_q, link_drop_d;
  logic               rst_ok, done_s, soft_rst;

  assign rst_ok = rst_sync_q[1];
  assign done_s = done_sync_q[1];

`ifdef RESET_SEQ_SOFT_RST_EN
  assign soft_rst = soft_rst_i;
`else
  assign soft_rst = 1'b0;
`endif

  // Next state, counters and registered output values (outputs follow the next state).
  always_comb begin
    rst_sync_d  = {rst_sync_q[0], 1'b1};
    done_sync_d = {done_sync_q[0], resetdone_i};
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    to_cnt_d    = to_cnt_q;
    retry_cnt_d = retry_cnt_q;
    link_drop_d = 1'b0;

    if (soft_rst) begin
      state_d     = ST_ASSERT;
      retry_cnt_d = '0;
    end else if (rst_ok) begin
      case (state_q)
        ST_ASSERT: begin
          if (hold_cnt_q == HOLD_LAST) state_d = ST_NET_WAIT;
          else                         hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
        ST_NET_WAIT: begin
          // A resetdone seen on the timeout cycle still wins.
          if (done_s) begin
            state_d = ST_RUN;
          end else if (to_cnt_q == TO_LAST) begin
            if (retry_cnt_q == RETRY_LAST) begin
              state_d = ST_FAIL;
            end else begin
              retry_cnt_d = retry_cnt_q + RETRY_W'(1);
              state_d     = ST_ASSERT;
            end
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
        ST_RUN: begin
          if (!done_s) begin
            link_drop_d = 1'b1;
            state_d     = ST_ASSERT;
          end
        end
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_ASSERT;
      endcase
    end

    if (soft_rst || (state_d != state_q)) begin
      hold_cnt_d = '0;
      to_cnt_d   = '0;
    end
    if ((state_d == ST_RUN) && (state_q != ST_RUN)) retry_cnt_d = '0;

    net_areset_d = (state_d == ST_ASSERT) || (state_d == ST_FAIL);
    sys_rst_n_d  = (state_d == ST_RUN);
    sys_rst_d    = ~sys_rst_n_d;
    resetdone_d  = (state_d == ST_RUN);
    fail_d       = (state_d == ST_FAIL);
  end

  always_ff @(posedge sys_clk_i or negedge areset_n_i) begin
    if (!areset_n_i) begin
      rst_sync_q   <= '0;
      done_sync_q  <= '0;
      state_q      <= ST_ASSERT;
      hold_cnt_q   <= '0;
      to_cnt_q     <= '0;
      retry_cnt_q  <= '0;
      net_areset_q <= 1'b1;
      sys_rst_n_q  <= 1'b0;
      sys_rst_q    <= 1'b1;
      resetdone_q  <= 1'b0;
      fail_q       <= 1'b0;
      link_drop_q  <= 1'b0;
    end else begin
      rst_sync_q   <= rst_sync_d;
      done_sync_q  <= done_sync_d;
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      to_cnt_q     <= to_cnt_d;
      retry_cnt_q  <= retry_cnt_d;
      net_areset_q <= net_areset_d;
      sys_rst_n_q  <= sys_rst_n_d;
      sys_rst_q    <= sys_rst_d;
      resetdone_q  <= resetdone_d;
      fail_q       <= fail_d;
      link_drop_q  <= link_drop_d;
    end
  end

  assign net_areset_o = net_areset_q;
  assign sys_rst_n_o  = sys_rst_n_q;
  assign sys_rst_o    = sys_rst_q;
  assign resetdone_o  = resetdone_q;
  assign fail_o       = fail_q;
  assign link_drop_o  = link_drop_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_reset_seq.sv
// Self-checking bench for reset_seq: directed sequences plus randomized resetdone/reset
// activity, compared every cycle against a countdown-based reference model.
module tb_reset_seq;

  localparam int HOLD = 16;
  localparam int TMO  = 64;
  localparam int RMAX = 2;
  localparam logic [8:0] RST_VEC = 9'b1_0_1_0_0_0_000;

  logic       clk;
  logic       areset_n;
  logic       resetdone;
  logic       soft_rst;
  logic       net_areset, sys_rst_n, sys_rst, rd_o, fail, link_drop;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  reset_seq #(
    .HOLD_CYCLES   (HOLD),
    .TIMEOUT_CYCLES(TMO),
    .RETRY_MAX     (RMAX)
  ) dut (
    .sys_clk_i   (clk),
    .areset_n_i  (areset_n),
    .resetdone_i (resetdone),
`ifdef RESET_SEQ_SOFT_RST_EN
    .soft_rst_i  (soft_rst),
`endif
    .net_areset_o(net_areset),
    .sys_rst_n_o (sys_rst_n),
    .sys_rst_o   (sys_rst),
    .resetdone_o (rd_o),
    .fail_o      (fail),
    .link_drop_o (link_drop),
    .state_o     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: phase 0 hold, 1 wait, 2 run, 3 fail; m_left counts cycles remaining.
  int         m_phase, m_left, m_used, m_rel;
  logic [1:0] m_pipe;
  logic       m_drop;

  task automatic model_reset();
    m_phase = 0; m_left = HOLD; m_used = 0; m_rel = 0; m_pipe = 2'b00; m_drop = 1'b0;
  endtask

  task automatic model_step(input logic rd, input logic sr);
    logic ds;
    logic ok;
    ds = m_pipe[1];
    ok = (m_rel >= 2);
    m_pipe = {m_pipe[0], rd};
    if (m_rel < 2) m_rel++;
    m_drop = 1'b0;
    if (sr) begin
      m_phase = 0; m_left = HOLD; m_used = 0;
    end else if (ok) begin
      case (m_phase)
        0: begin
          m_left--;
          if (m_left == 0) begin m_phase = 1; m_left = TMO; end
        end
        1: begin
          if (ds) begin
            m_phase = 2; m_used = 0;
          end else begin
            m_left--;
            if (m_left == 0) begin
              if (m_used == RMAX) m_phase = 3;
              else begin m_used++; m_phase = 0; m_left = HOLD; end
            end
          end
        end
        2: if (!ds) begin m_drop = 1'b1; m_phase = 0; m_left = HOLD; end
        default: ;
      endcase
    end
  endtask

  function automatic logic [8:0] exp_outs();
    logic n, r;
    n = (m_phase == 0) || (m_phase == 3);
    r = (m_phase == 2);
    return {n, r, ~r, r, (m_phase == 3), m_drop, 3'(m_phase)};
  endfunction

  function automatic logic [8:0] got_vec();
    return {net_areset, sys_rst_n, sys_rst, rd_o, fail, link_drop, state};
  endfunction

  // One clock: drive resetdone, step the model on the edge, compare just after it.
  task automatic cyc(input logic rd);
    resetdone = rd;
    @(posedge clk);
    if (areset_n) model_step(resetdone, soft_rst);
    #1;
    check_eq("outs", 32'(got_vec()), 32'(exp_outs()));
  endtask

  task automatic assert_rst();
    #2;
    areset_n = 1'b0;
    #1;
    check_eq("async_rst", 32'(got_vec()), 32'(RST_VEC));
    model_reset();
    cyc(resetdone);
    cyc(resetdone);
  endtask

  task automatic release_rst();
    @(negedge clk);
    areset_n = 1'b1;
  endtask

  initial begin
    int   t, falls, ld, nh, changes;
    logic prev;
    logic [8:0] snap;

    areset_n = 1'b0; resetdone = 1'b0; soft_rst = 1'b0;
    model_reset();
    #12;
    check_eq("reset_vals", 32'(got_vec()), 32'(RST_VEC));

    // Normal bring-up.
    release_rst();
    t = 0;
    while (net_areset !== 1'b0 && t < 100) begin cyc(1'b0); t++; end
    check_eq("net_fall_edge", 32'(t), 32'(HOLD + 2));
    repeat (10) cyc(1'b0);
    t = 0;
    do begin cyc(1'b1); t++; end while (sys_rst_n !== 1'b1 && t < 20);
    check_eq("rstn_rise_edges", 32'(t), 32'd3);
    check_eq("sys_rst_low", 32'(sys_rst), 32'd0);
    check_eq("resetdone_o", 32'(rd_o), 32'd1);

    // Link drop in RUN for 5 cycles.
    repeat (20) cyc(1'b1);
    ld = 0; nh = 0;
    for (int i = 0; i < 5; i++) begin cyc(1'b0); ld += int'(link_drop); nh += int'(net_areset); end
    for (int i = 0; i < 40; i++) begin cyc(1'b1); ld += int'(link_drop); nh += int'(net_areset); end
    check_eq("drop_pulse_len", 32'(ld), 32'd1);
    check_eq("drop_hold_len", 32'(nh), 32'(HOLD));
    check_eq("resequenced", 32'(sys_rst_n), 32'd1);

    // Async reset mid-RUN, then mid-NET_WAIT, then restart from edge 0.
    assert_rst();
    release_rst();
    t = 0;
    while (net_areset !== 1'b0 && t < 100) begin cyc(1'b0); t++; end
    repeat (30) cyc(1'b0);
    check_eq("in_net_wait", 32'(state), 32'd1);
    assert_rst();
    release_rst();
    t = 0;
    while (net_areset !== 1'b0 && t < 100) begin cyc(1'b0); t++; end
    check_eq("restart_fall_edge", 32'(t), 32'(HOLD + 2));

    // One timeout, recover in the second wait, then show fresh retries after a drop.
    repeat (TMO) cyc(1'b0);
    check_eq("retry_assert", 32'(net_areset), 32'd1);
    t = 0;
    while (net_areset !== 1'b0 && t < 40) begin cyc(1'b0); t++; end
    check_eq("retry_hold_len", 32'(t), 32'(HOLD));
    repeat (5) cyc(1'b0);
    t = 0;
    while (sys_rst_n !== 1'b1 && t < 20) begin cyc(1'b1); t++; end
    check_eq("run_after_retry", 32'(state), 32'd2);
    t = 0; falls = 0; prev = net_areset;
    while (fail !== 1'b1 && t < 600) begin
      cyc(1'b0); t++;
      if (prev && !net_areset) falls++;
      prev = net_areset;
    end
    check_eq("fresh_retries", 32'(falls), 32'(RMAX + 1));

    // resetdone never arrives: exhaust retries, then stay frozen.
    assert_rst();
    release_rst();
    t = 0; falls = 0; prev = net_areset;
    while (fail !== 1'b1 && t < 400) begin
      cyc(1'b0); t++;
      if (prev && !net_areset) falls++;
      prev = net_areset;
    end
    check_eq("fail_edge", 32'(t), 32'(HOLD + 2 + TMO + RMAX * (HOLD + TMO)));
    check_eq("net_pulses", 32'(falls), 32'(RMAX + 1));
    check_eq("fail_state", 32'(state), 32'd3);
    snap = got_vec(); changes = 0;
    repeat (1000) begin cyc(1'b0); if (got_vec() !== snap) changes++; end
    check_eq("fail_frozen", 32'(changes), 32'd0);

`ifdef RESET_SEQ_SOFT_RST_EN
    // Soft reset out of FAIL.
    soft_rst = 1'b1;
    cyc(1'b0);
    soft_rst = 1'b0;
    check_eq("soft_fail_clr", 32'(fail), 32'd0);
    check_eq("soft_net_high", 32'(net_areset), 32'd1);
    ld = 0;
    for (int i = 0; i < 40; i++) begin cyc(1'b1); ld += int'(link_drop); end
    check_eq("soft_no_drop", 32'(ld), 32'd0);
    check_eq("soft_run", 32'(sys_rst_n), 32'd1);
`endif

    // Randomized resetdone levels, async resets and (if present) soft resets.
    assert_rst();
    release_rst();
    for (int s = 0; s < 50; s++) begin
      int   len;
      logic lvl;
      len = int'($urandom_range(120, 1));
      lvl = ($urandom_range(2, 0) != 0);
      if ($urandom_range(5, 0) == 0) begin
        assert_rst();
        release_rst();
      end
`ifdef RESET_SEQ_SOFT_RST_EN
      if ($urandom_range(7, 0) == 0) begin
        soft_rst = 1'b1;
        cyc(lvl);
        soft_rst = 1'b0;
      end
`endif
      repeat (len) cyc(lvl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
